// File: rtl/fifo_sc_lvl_pkg.sv
// Shared types, flag-priority constants and parameter-range helpers for the
// level-reporting single-clock FIFO.
package fifo_sc_lvl_pkg;

    // A sticky error that is raised in the same cycle as clr_err stays raised.
    localparam bit ERR_SET_WINS_CLR = 1'b1;
    // Flush empties the buffer but leaves the sticky error flags alone.
    localparam bit FLUSH_CLEARS_ERR = 1'b0;

    typedef enum logic [1:0] {
        LVL_HOLD = 2'd0,
        LVL_INC  = 2'd1,
        LVL_DEC  = 2'd2
    } lvl_op_e;

    function automatic int level_width(input int d);
        return d + 1;
    endfunction

    function automatic bit depth_ok(input int d);
        return (d >= 1) && (d <= 30);
    endfunction

    function automatic bit afull_ok(input int d, input int thr);
        return (thr >= 1) && (thr <= (1 << d));
    endfunction

    function automatic bit aempty_ok(input int d, input int thr);
        return (thr >= 0) && (thr < (1 << d));
    endfunction

endpackage

// File: rtl/fifo_sc_lvl_if.sv
// Producer/consumer bundle of the level-reporting FIFO; the FIFO takes the
// slave view, whoever drives writes, reads and control takes the master view.
interface fifo_sc_lvl_if #(
    parameter int D = 4,
    parameter int W = 16
);
    logic         flush;
    logic         write;
    logic [W-1:0] data_in;
    logic         read;
    logic         clr_err;
    logic [W-1:0] data_out;
    logic         valid_out;
    logic         full;
    logic         empty;
    logic         almost_full;
    logic         almost_empty;
    logic [D:0]   level;
    logic         overflow;
    logic         underflow;

    modport master (
        output flush, write, data_in, read, clr_err,
        input  data_out, valid_out, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );

    modport slave (
        input  flush, write, data_in, read, clr_err,
        output data_out, valid_out, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );
endinterface

// File: rtl/fifo_sc_lvl_ram.sv
// Simple dual-port storage for the FIFO: one write port, one registered read
// port, no reset so it maps onto block RAM.
module fifo_sc_lvl_ram #(
    parameter int AW = 4,
    parameter int W  = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [2**AW];
    logic [W-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;
endmodule

// File: rtl/fifo_sc_lvl.sv
// Single-clock FIFO with fill level, almost flags, flush and sticky errors.
// Define FIFO_SC_LVL_FWFT_EN for first-word-fall-through output behaviour.
module fifo_sc_lvl
    import fifo_sc_lvl_pkg::*;
#(
    parameter int D          = 4,
    parameter int W          = 16,
    parameter int AFULL_THR  = 2**D - 1,
    parameter int AEMPTY_THR = 1
) (
    input logic         clk,
    input logic         rst,
    fifo_sc_lvl_if.slave bus
);
    localparam int DEPTH = 2**D;
    localparam int LW    = level_width(D);

    typedef logic [LW-1:0] level_t;
    typedef logic [D-1:0]  ptr_t;

    localparam level_t DEPTH_L = level_t'(DEPTH);
    localparam level_t AFULL_L = level_t'(AFULL_THR);
    localparam level_t AEMPTY_L = level_t'(AEMPTY_THR);

    if (!depth_ok(D)) begin : g_bad_depth
        $error("fifo_sc_lvl: D must be >= 1");
    end
    if (!afull_ok(D, AFULL_THR)) begin : g_bad_afull
        $error("fifo_sc_lvl: AFULL_THR must lie in 1..2**D");
    end
    if (!aempty_ok(D, AEMPTY_THR)) begin : g_bad_aempty
        $error("fifo_sc_lvl: AEMPTY_THR must lie in 0..2**D-1");
    end

    ptr_t    wr_ptr_reg;
    ptr_t    rd_ptr_reg;
    level_t  level_reg;
    logic    valid_reg;
    logic    loaded_reg;
    logic    ovf_reg;
    logic    unf_reg;

    logic    full;
    logic    empty;
    logic    wr_ok;
    logic    rd_ok;
    logic    ram_re;
    logic    ovf_set;
    logic    unf_set;
    logic    ovf_next;
    logic    unf_next;
    logic [W-1:0] ram_q;
    lvl_op_e lvl_op;

    assign full = (level_reg == DEPTH_L);

`ifdef FIFO_SC_LVL_FWFT_EN
    // Words still in RAM; the output register holds the head when valid.
    level_t ram_cnt;
    assign ram_cnt = level_reg - level_t'(valid_reg);
    assign empty   = !valid_reg;
    assign ram_re  = !bus.flush && (ram_cnt != '0) && (!valid_reg || rd_ok);
`else
    assign empty   = (level_reg == '0);
    assign ram_re  = rd_ok;
`endif

    assign wr_ok   = bus.write && !full  && !bus.flush;
    assign rd_ok   = bus.read  && !empty && !bus.flush;
    assign ovf_set = bus.write && full   && !bus.flush;
    assign unf_set = bus.read  && empty  && !bus.flush;

    always_comb begin
        lvl_op = LVL_HOLD;
        if (wr_ok && !rd_ok) begin
            lvl_op = LVL_INC;
        end else if (rd_ok && !wr_ok) begin
            lvl_op = LVL_DEC;
        end
    end

    always_comb begin
        ovf_next = 1'b0;
        unf_next = 1'b0;
        if (ERR_SET_WINS_CLR) begin
            ovf_next = ovf_set || (ovf_reg && !bus.clr_err);
            unf_next = unf_set || (unf_reg && !bus.clr_err);
        end else begin
            ovf_next = (ovf_reg || ovf_set) && !bus.clr_err;
            unf_next = (unf_reg || unf_set) && !bus.clr_err;
        end
        if (FLUSH_CLEARS_ERR && bus.flush) begin
            ovf_next = 1'b0;
            unf_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            valid_reg  <= 1'b0;
            loaded_reg <= 1'b0;
            ovf_reg    <= 1'b0;
            unf_reg    <= 1'b0;
        end else begin
            if (bus.flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                level_reg  <= '0;
                valid_reg  <= 1'b0;
            end else begin
                if (wr_ok) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end
                if (ram_re) begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
                case (lvl_op)
                    LVL_INC: level_reg <= level_reg + 1'b1;
                    LVL_DEC: level_reg <= level_reg - 1'b1;
                    default: level_reg <= level_reg;
                endcase
`ifdef FIFO_SC_LVL_FWFT_EN
                valid_reg <= ram_re || (valid_reg && !rd_ok);
`else
                valid_reg <= rd_ok;
`endif
            end
            // data_out reads as zero until the RAM read register has been loaded once.
            if (ram_re) begin
                loaded_reg <= 1'b1;
            end
            ovf_reg <= ovf_next;
            unf_reg <= unf_next;
        end
    end

    fifo_sc_lvl_ram #(
        .AW (D),
        .W  (W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr_reg),
        .wdata (bus.data_in),
        .re    (ram_re),
        .raddr (rd_ptr_reg),
        .rdata (ram_q)
    );

    assign bus.data_out     = loaded_reg ? ram_q : '0;
    assign bus.valid_out    = valid_reg;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (level_reg >= AFULL_L);
    assign bus.almost_empty = (level_reg <= AEMPTY_L);
    assign bus.level        = level_reg;
    assign bus.overflow     = ovf_reg;
    assign bus.underflow    = unf_reg;
endmodule
